imem_boot_loader: RTL and testbench

- Program loader and write-port controller for the 32-bit instruction memory.
- Receives a framed byte stream from the UART RX block, assembles little-endian 32-bit words and issues single-cycle writes to the instruction memory write port.
- Holds the CPU core in reset for the whole load and releases it only after a checksum-verified image is in memory.
- Sits between uart_rx, instruction memory and the core reset input. With no load performed, the core runs the power-on memory image.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/byte_gap_timer.sv | 30 +++
 rtl/imem_boot_loader.sv | 152 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory boot loader
//   state_t      - loader FSM states
//   HDR_BYTE_DEF - default frame start byte
//   BIDX_W       - width of the byte-within-word index
package imem_loader_pkg;
    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
    localparam int         BIDX_W       = 2;
endpackage

// File: rtl/byte_gap_timer.sv
// byte_gap_timer: counts idle cycles between received bytes and flags a timeout
//   iClk    - system clock
//   iRst_n  - asynchronous active-low reset
//   enable  - count only while a frame is in progress; counter held at 0 otherwise
//   kick    - a byte arrived this cycle; restarts the count
//   expired - this idle cycle makes the gap reach TIMEOUT_CYC
module byte_gap_timer #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic enable,
    input  logic kick,
    output logic expired
);
    localparam int GW = $clog2(TIMEOUT_CYC + 1);

    logic [GW-1:0] gap_q, gap_d;

    // Firing one cycle early lets the FSM leave on the very edge where the gap hits the limit.
    always_comb begin
        gap_d   = (!enable || kick) ? '0 : gap_q + 1'b1;
        expired = enable && !kick && (gap_q == GW'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) gap_q <= '0;
        else         gap_q <= gap_d;
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed, checksummed UART byte stream into instruction memory
//   iClk/iRst_n          - clock, asynchronous active-low reset
//   iRxData/iRxValid     - received byte and its one-cycle strobe
//   oWrEn/oWrAddr/oWrData - single-cycle instruction memory write (byte address)
//   oCpuRst_n            - core reset, released only in IDLE and after a verified load
//   oBusy/oDone/oErr     - frame in progress / load succeeded / load failed
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int         DEPTH       = 64,
    parameter int         TIMEOUT_CYC = 1000000,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [7:0]  iRxData,
    input  logic        iRxValid,
    output logic        oWrEn,
    output logic [31:0] oWrAddr,
    output logic [31:0] oWrData,
    output logic        oCpuRst_n,
    output logic        oBusy,
    output logic        oDone,
    output logic        oErr
);
    localparam int WIW = $clog2(DEPTH + 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_lo_q, cnt_lo_d;
    logic [WIW-1:0]      count_q, count_d;
    logic [WIW-1:0]      word_idx_q, word_idx_d;
    logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [31:0]         word_q, word_d;
    logic [7:0]          sum_q, sum_d;
    logic                wr_en_q, wr_en_d;
    logic [31:0]         wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [15:0]         cnt16;
    logic                in_frame;
    logic                expired;

    assign in_frame = (state_q == CNT_LO) || (state_q == CNT_HI) || (state_q == DATA) || (state_q == CHK);
    assign cnt16    = {iRxData, cnt_lo_q};

    byte_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .enable  (in_frame),
        .kick    (iRxValid),
        .expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        cnt_lo_d   = cnt_lo_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        sum_d      = sum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (expired) begin
            state_d = ERR;
        end else if (iRxValid) begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (iRxData == HDR_BYTE) begin
                        state_d    = CNT_LO;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        sum_d      = '0;
                    end
                end
                CNT_LO: begin
                    cnt_lo_d = iRxData;
                    state_d  = CNT_HI;
                end
                CNT_HI: begin
                    count_d = cnt16[WIW-1:0];
                    state_d = (cnt16 > 16'(DEPTH)) ? ERR : (cnt16 == 16'd0) ? CHK : DATA;
                end
                DATA: begin
                    word_d[8*byte_idx_q +: 8] = iRxData;
                    sum_d      = sum_q + iRxData;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == '1) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = 32'(word_idx_q) << 2;
                        wr_data_d  = word_d;
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = (word_idx_d == count_q) ? CHK : DATA;
                    end
                end
                CHK:     state_d = (iRxData == sum_q) ? DONE : ERR;
                default: state_d = IDLE;
            endcase
        end
        // Status outputs are registered copies of the next state so they change with it.
        cpu_rst_n_d = (state_d == IDLE) || (state_d == DONE);
        busy_d      = (state_d == CNT_LO) || (state_d == CNT_HI) || (state_d == DATA) || (state_d == CHK);
        done_d      = state_d == DONE;
        err_d       = state_d == ERR;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= IDLE;
            cnt_lo_q    <= '0;
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            sum_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_lo_q    <= cnt_lo_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            sum_q       <= sum_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign oWrEn     = wr_en_q;
    assign oWrAddr   = wr_addr_q;
    assign oWrData   = wr_data_q;
    assign oCpuRst_n = cpu_rst_n_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oErr      = err_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed, scoreboard-checked bench for imem_boot_loader
module tb_imem_boot_loader;
    localparam int TO = 16;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic [7:0]  iRxData = 8'h00;
    logic        iRxValid = 1'b0;
    logic        oWrEn;
    logic [31:0] oWrAddr;
    logic [31:0] oWrData;
    logic        oCpuRst_n;
    logic        oBusy;
    logic        oDone;
    logic        oErr;

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] sb[$];
    logic        prev_wr = 1'b0;

    imem_boot_loader #(.DEPTH(64), .TIMEOUT_CYC(TO), .HDR_BYTE(8'hA5)) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iRxData   (iRxData),
        .iRxValid  (iRxValid),
        .oWrEn     (oWrEn),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData),
        .oCpuRst_n (oCpuRst_n),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oErr      (oErr)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write must match the oldest expected write and never be back to back.
    always @(negedge iClk) begin
        if (oWrEn === 1'b1) begin
            check("wr_not_consecutive", {63'd0, prev_wr}, 64'd0);
            check("wr_expected", {63'd0, sb.size() > 0}, 64'd1);
            if (sb.size() > 0) check("wr_addr_data", {oWrAddr, oWrData}, sb.pop_front());
        end
        prev_wr = (oWrEn === 1'b1);
    end

    task automatic send(input logic [7:0] b);
        iRxData  = b;
        iRxValid = 1'b1;
        @(posedge iClk);
        #1;
        iRxValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic status(input string tag, input logic busy, input logic done, input logic err, input logic cpu);
        check(tag, {60'd0, oBusy, oDone, oErr, oCpuRst_n}, {60'd0, busy, done, err, cpu});
    endtask

    // Nominal two-word frame body after the header, with a selectable checksum byte.
    task automatic send_body(input logic [7:0] chk_b);
        logic [7:0] body[10] = '{8'h02, 8'h00, 8'h93, 8'h83, 8'h20, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        sb.push_back({32'h0, 32'h00208393});
        sb.push_back({32'h4, 32'h00000013});
        for (int i = 0; i < 10; i++) begin
            send(body[i]);
            if (i == 5) idle(2);
        end
        status("pre_chk", 1, 0, 0, 0);
        send(chk_b);
        idle(1);
    endtask

    initial begin
        #3;
        check("rst_outputs", {oWrEn, oWrAddr, oWrData, oCpuRst_n, oBusy, oDone, oErr}, 69'd0);
        @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        idle(1);
        status("idle_after_rst", 0, 0, 0, 1);

        send(8'hA5);
        send_body(8'h49);
        status("nominal_done", 0, 1, 0, 1);
        check("nominal_drained", 64'(sb.size()), 64'd0);

        send(8'h55);
        idle(1);
        status("noise_ignored", 0, 1, 0, 1);
        send(8'hA5);
        status("reload_hdr", 1, 0, 0, 0);
        send_body(8'h49);
        status("reload_done", 0, 1, 0, 1);

        send(8'hA5);
        send_body(8'h4A);
        status("bad_chk", 0, 0, 1, 0);
        check("bad_chk_drained", 64'(sb.size()), 64'd0);

        send(8'hA5);
        send(8'h41);
        send(8'h00);
        status("oversize", 0, 0, 1, 0);
        idle(3);

        send(8'hA5);
        send(8'h00);
        send(8'h00);
        status("zero_in_chk", 1, 0, 0, 0);
        send(8'h00);
        status("zero_done", 0, 1, 0, 1);

        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send(8'h93);
        send(8'h83);
        idle(TO - 1);
        status("timeout_before", 1, 0, 0, 0);
        idle(1);
        status("timeout_at", 0, 0, 1, 0);
        idle(4);

        send(8'hA5);
        send(8'h02);
        send(8'h00);
        sb.push_back({32'h0, 32'h11223344});
        send(8'h44);
        send(8'h33);
        send(8'h22);
        send(8'h11);
        send(8'h55);
        #2;
        iRst_n = 1'b0;
        #1;
        check("async_rst", {oWrEn, oWrAddr, oWrData, oCpuRst_n, oBusy, oDone, oErr}, 69'd0);
        @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        idle(1);
        status("after_rst_idle", 0, 0, 0, 1);
        send(8'hA5);
        send_body(8'h49);
        status("after_rst_done", 0, 1, 0, 1);
        idle(3);
        check("final_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
